// File: rtl/mem_pkg.sv
// Shared definitions for the RAM port 2 arbiter slice.
//   arb_state_e : arbiter lock state (IDLE / LOCK0 / LOCK1)
//   MASK_*      : common byte-lane masks for byte, halfword and word accesses
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way grant for RAM port 2.
//   req0/req1 : transfer requests
//   prio      : requester that wins a simultaneous request in IDLE
//   state     : lock state; a locked state admits only its owner
//   gnt0/gnt1 : one-hot (or zero) grant
module rr_arb2
  import mem_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       prio,
  input  arb_state_e state,
  output logic       gnt0,
  output logic       gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      LOCK0: gnt0 = req0;
      LOCK1: gnt1 = req1;
      default: begin
        if (req0 && (!req1 || !prio)) gnt0 = 1'b1;
        else if (req1)                gnt1 = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port 2 between requester 0 (CPU LSU) and requester 1 (loader/DMA).
// Grant is combinational in the request cycle; writes commit on that edge and
// read data is registered one cycle later. Round-robin with optional lock.
//   clk, rst                     : clock, synchronous active-high reset
//   reqN/weN/lockN/addrN/wdataN/maskN : requester N transfer request
//   gntN                         : transfer accepted this cycle
//   rvalidN/rdataN               : registered read response
//   ram_a2/ram_di2/ram_m2/ram_we2: RAM port 2 drive
//   ram_do2                      : RAM port 2 read data (combinational)
module ram_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned RESET_PRIO = 0,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  input  logic [3:0]        mask0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [31:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  input  logic [3:0]        mask1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [31:0]       rdata1,
  output logic [ADDR_W-1:0] ram_a2,
  output logic [31:0]       ram_di2,
  output logic [3:0]        ram_m2,
  output logic              ram_we2,
  input  logic [31:0]       ram_do2
);

  arb_state_e state, state_next;
  logic       prio;
  logic       arb_gnt0, arb_gnt1;

  rr_arb2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .prio  (prio),
    .state (state),
    .gnt0  (arb_gnt0),
    .gnt1  (arb_gnt1)
  );

  // Grants are forced off during reset so no RAM write can slip through.
  always_comb begin
    gnt0 = arb_gnt0 && !rst;
    gnt1 = arb_gnt1 && !rst;
  end

  // Port mux: requester 0 is the default path when nobody is granted.
  always_comb begin
    if (gnt1) begin
      ram_a2  = addr1;
      ram_di2 = wdata1;
      ram_m2  = mask1;
      ram_we2 = we1;
    end else begin
      ram_a2  = addr0;
      ram_di2 = wdata0;
      ram_m2  = mask0;
      ram_we2 = gnt0 && we0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (gnt0 && lock0)      state_next = LOCK0;
        else if (gnt1 && lock1) state_next = LOCK1;
      end
      LOCK0: if (!req0 || !lock0) state_next = IDLE;
      LOCK1: if (!req1 || !lock1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio    <= (RESET_PRIO != 0);
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      if (gnt0)      prio <= 1'b1;
      else if (gnt1) prio <= 1'b0;
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0 && !we0) rdata0 <= ram_do2;
      if (gnt1 && !we1) rdata1 <= ram_do2;
    end
  end

endmodule
